score_keeper: RTL and testbench
===============================

Name: score_keeper

Overview:
Produces the running game score consumed by the level/speed logic; the game FSM and collision logic feed it point events.
- Counts one point per rising edge of point_in while a game is active, saturating at MAX_SCORE.
- Keeps a high score across games.
- Converts the live score to 3-digit BCD with a sequential double-dabble engine, for the HEX display drivers.

Parameters:
SCORE_W, 12, width of score and high_score (drives the 12-bit score input of the level logic)
MAX_SCORE, 999, saturation value; must fit in 3 BCD digits
BCD_ITERS, 12, double-dabble shift iterations; equals SCORE_W

Ports:
clock  input  1  system clock
resetn  input  1  reset, active-low, asynchronous
game_active  input  1  high while a run is in progress; points ignored when low
point_in  input  1  point request from game logic; may be held multiple cycles; counted once per rising edge
clear  input  1  synchronous score clear at start of new game
game_over  input  1  end-of-game indication; rising edge triggers high-score compare
score  output  12  current score, binary
high_score  output  12  best score since reset, binary
score_bcd  output  12  {hundreds, tens, ones} BCD of score
bcd_valid  output  1  score_bcd matches the current score
new_high  output  1  one-cycle pulse when high_score is updated

Behaviour:
- Reset (async, resetn=0): score=0, high_score=0, score_bcd=0, bcd_valid=1, new_high=0, edge-detect registers=0, converter in IDLE, pending=0.
- Edge detect: point_rise = point_in & ~point_q, where point_q is point_in registered; same scheme for game_over. Both inputs are synchronous to clock.
- Score update, priority per cycle:
  1. clear: score<=0.
  2. else if point_rise & game_active & score<MAX_SCORE: score<=score+1.
  3. else hold.
- Score latency: 1 cycle from point_in rising at the sampling edge.
- Saturation: at MAX_SCORE, further edges are ignored; no wrap.
- High score: on game_over rise, if score>high_score then high_score<=score and new_high=1 for exactly that cycle.
  - Equal score: no update, no pulse.
  - Evaluated on the pre-update score value if a point lands the same cycle.
  - clear does not touch high_score; only resetn does.
- Converter FSM, states IDLE, LOAD, SHIFT, DONE:
  - IDLE: when score differs from last converted value (last_bin) -> LOAD, bcd_valid<=0.
  - LOAD (1 cycle): capture bin<=score, last_bin<=score, bcd work reg<=0, iter<=0.
  - SHIFT (BCD_ITERS cycles): each cycle, add 3 to every BCD digit >=5, then shift {bcd,bin} left 1; iter++. After BCD_ITERS iterations -> DONE.
  - DONE (1 cycle): score_bcd<=work reg; then:
    - if score!=last_bin, go to LOAD with bcd_valid held low;
    - else bcd_valid<=1 and go to IDLE.
  - Latency: score changes at edge N; score_bcd/bcd_valid update at edge N+15. Converter sees the change at N+1, LOAD at N+1->N+2, 12 SHIFT cycles, DONE.
  - Score changes mid-conversion do not abort the conversion; they are caught by the DONE re-check. score_bcd never shows a partially shifted value.
  - clear mid-conversion is handled the same way; the final score_bcd is 000.
- Widths: score compare unsigned; BCD digits 4 bits each; work register 12+12 bits.
- Reset mid-conversion: immediate return to IDLE with all reset values.

Test Plan:
- Reset, then 7 single-cycle point_in pulses with game_active=1 -> score=7; bcd_valid rises 15 cycles after the last increment with score_bcd=0x007.
- point_in held high 10 cycles -> score increments by exactly 1; point_in pulsed with game_active=0 -> score unchanged.
- Preload to 998 via pulses, then 3 more pulses -> score=999 and stays; score_bcd=0x999.
- Score 35, game_over rise -> high_score=35, new_high high 1 cycle. clear, score 20, game_over -> high_score stays 35, no pulse. Score 35 again -> no pulse.
- Two increments 3 cycles apart (score 41->42->43) -> bcd_valid never high with 0x042 stale mismatch; final score_bcd=0x043, bcd_valid=1.
- clear and point_rise same cycle -> score=0. resetn low during SHIFT -> all outputs at reset values, bcd_valid=1 immediately.

Source files
------------

// File: rtl/score_keeper.sv
// score_keeper
//   Running game score with saturation, a high score kept across games, and
//   a sequential double-dabble converter that feeds the HEX display drivers.
//
// Ports:
//   clock        system clock
//   resetn       asynchronous active-low reset
//   game_active  points are only counted while high
//   point_in     point request; one point per rising edge
//   clear        synchronous score clear for a new game
//   game_over    rising edge triggers the high-score compare
//   score        current score, binary
//   high_score   best score since reset, binary
//   score_bcd    {hundreds, tens, ones} BCD of score
//   bcd_valid    score_bcd matches the current score
//   new_high     one-cycle pulse when high_score is updated
module score_keeper #(
  parameter int SCORE_W   = 12,
  parameter int MAX_SCORE = 999,
  parameter int BCD_ITERS = 12
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               game_active,
  input  logic               point_in,
  input  logic               clear,
  input  logic               game_over,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] high_score,
  output logic [11:0]        score_bcd,
  output logic               bcd_valid,
  output logic               new_high
);

  localparam int ITER_W = $clog2(BCD_ITERS);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} conv_state_e;

  logic               point_q, point_d;
  logic               game_over_q, game_over_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [SCORE_W-1:0] high_score_q, high_score_d;
  logic               new_high_q, new_high_d;
  logic               point_rise, game_over_rise;

  conv_state_e        state_q;
  logic [SCORE_W-1:0] bin_q, last_bin_q;
  logic [11:0]        bcd_work_q;
  logic [ITER_W-1:0]  iter_q;
  logic [11:0]        score_bcd_q;
  logic               bcd_valid_q;

  logic [11:0]        bcd_adj;
  logic [11:0]        shift_bcd;
  logic [SCORE_W-1:0] shift_bin;

  // Score, high score and edge detectors.
  always_comb begin
    point_d        = point_in;
    game_over_d    = game_over;
    point_rise     = point_in & ~point_q;
    game_over_rise = game_over & ~game_over_q;

    score_d = score_q;
    if (clear) begin
      score_d = '0;
    end else if (point_rise && game_active && (score_q < SCORE_W'(MAX_SCORE))) begin
      score_d = score_q + 1'b1;
    end

    // Compare uses the registered score, so a point landing in the same
    // cycle is not included.
    high_score_d = high_score_q;
    new_high_d   = 1'b0;
    if (game_over_rise && (score_q > high_score_q)) begin
      high_score_d = score_q;
      new_high_d   = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      point_q      <= 1'b0;
      game_over_q  <= 1'b0;
      score_q      <= '0;
      high_score_q <= '0;
      new_high_q   <= 1'b0;
    end else begin
      point_q      <= point_d;
      game_over_q  <= game_over_d;
      score_q      <= score_d;
      high_score_q <= high_score_d;
      new_high_q   <= new_high_d;
    end
  end

  // One double-dabble step: add 3 to every digit >= 5, then shift
  // {bcd, bin} left by one.
  always_comb begin
    bcd_adj = bcd_work_q;
    for (int d = 0; d < 3; d++) begin
      if (bcd_work_q[4*d +: 4] >= 4'd5) begin
        bcd_adj[4*d +: 4] = bcd_work_q[4*d +: 4] + 4'd3;
      end
    end
    shift_bcd = {bcd_adj[10:0], bin_q[SCORE_W-1]};
    shift_bin = {bin_q[SCORE_W-2:0], 1'b0};
  end

  // Converter FSM. A score change during a conversion does not abort it;
  // the DONE state re-checks and starts over, keeping bcd_valid low so a
  // stale value is never flagged valid.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      bin_q       <= '0;
      last_bin_q  <= '0;
      bcd_work_q  <= '0;
      iter_q      <= '0;
      score_bcd_q <= '0;
      bcd_valid_q <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (score_q != last_bin_q) begin
            state_q     <= LOAD;
            bcd_valid_q <= 1'b0;
          end
        end
        LOAD: begin
          bin_q      <= score_q;
          last_bin_q <= score_q;
          bcd_work_q <= '0;
          iter_q     <= '0;
          state_q    <= SHIFT;
        end
        SHIFT: begin
          bcd_work_q <= shift_bcd;
          bin_q      <= shift_bin;
          iter_q     <= iter_q + 1'b1;
          if (iter_q == ITER_W'(BCD_ITERS - 1)) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          score_bcd_q <= bcd_work_q;
          if (score_q != last_bin_q) begin
            state_q <= LOAD;
          end else begin
            bcd_valid_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign score      = score_q;
  assign high_score = high_score_q;
  assign new_high   = new_high_q;
  assign score_bcd  = score_bcd_q;
  assign bcd_valid  = bcd_valid_q;

endmodule

// File: tb/tb_score_keeper.sv
// tb_score_keeper
//   Self-checking bench for score_keeper. Expected BCD results are queued
//   when the stimulus that causes them is driven and popped by a monitor
//   when bcd_valid rises.
module tb_score_keeper;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        game_active = 1'b0;
  logic        point_in = 1'b0;
  logic        clear = 1'b0;
  logic        game_over = 1'b0;
  logic [11:0] score;
  logic [11:0] high_score;
  logic [11:0] score_bcd;
  logic        bcd_valid;
  logic        new_high;

  int          errors = 0;
  int          checks = 0;
  int          model = 0;
  logic [11:0] exp_q[$];
  logic        prev_valid = 1'b1;

  always #5 clock = ~clock;

  score_keeper dut (
    .clock      (clock),
    .resetn     (resetn),
    .game_active(game_active),
    .point_in   (point_in),
    .clear      (clear),
    .game_over  (game_over),
    .score      (score),
    .high_score (high_score),
    .score_bcd  (score_bcd),
    .bcd_valid  (bcd_valid),
    .new_high   (new_high)
  );

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Every completed conversion must match the oldest queued expectation.
  always @(negedge clock) begin
    if (!resetn) begin
      prev_valid = 1'b1;
    end else begin
      if (bcd_valid && !prev_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_bcd: got %03h with nothing expected", score_bcd);
        end else begin
          logic [11:0] e;
          e = exp_q.pop_front();
          if (score_bcd !== e) begin
            errors++;
            $display("[TB] FAIL score_bcd: got %03h expected %03h", score_bcd, e);
          end
        end
      end
      prev_valid = bcd_valid;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse(input int gap);
    point_in = 1'b1;
    tick();
    point_in = 1'b0;
    if (game_active && model < 999) model++;
    repeat (gap - 1) tick();
  endtask

  task automatic burst(input int n, input int gap);
    repeat (n) pulse(gap);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    model = 0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      tick();
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain_%s: %0d results still pending, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (2) tick();
    checks++;
    if (score !== 12'd0 || high_score !== 12'd0 || new_high !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_bin: score=%0d high=%0d new_high=%b required 0 0 0",
               score, high_score, new_high);
    end
    checks++;
    if (score_bcd !== 12'h000 || bcd_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_bcd: bcd=%03h valid=%b required 000 1", score_bcd, bcd_valid);
    end
    resetn = 1'b1;
    game_active = 1'b1;
    tick();
  endtask

  task automatic test_count();
    int cnt;
    for (int i = 0; i < 6; i++) begin
      point_in = 1'b1;
      tick();
      point_in = 1'b0;
      model++;
      exp_q.push_back(to_bcd(model));
      repeat (19) tick();
    end
    point_in = 1'b1;
    tick();
    point_in = 1'b0;
    model++;
    exp_q.push_back(to_bcd(model));
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (!bcd_valid && cnt < 40);
    checks++;
    if (cnt != 15) begin
      errors++;
      $display("[TB] FAIL bcd_latency: got %0d cycles required 15", cnt);
    end
    checks++;
    if (score !== 12'd7) begin
      errors++;
      $display("[TB] FAIL count7: score=%0d required 7", score);
    end
    wait_drain("count");
  endtask

  task automatic test_hold_and_inactive();
    point_in = 1'b1;
    repeat (10) tick();
    point_in = 1'b0;
    model++;
    exp_q.push_back(to_bcd(model));
    tick();
    checks++;
    if (score !== 12'(model)) begin
      errors++;
      $display("[TB] FAIL held_point: score=%0d required %0d", score, model);
    end
    wait_drain("hold");
    game_active = 1'b0;
    pulse(4);
    checks++;
    if (score !== 12'd8) begin
      errors++;
      $display("[TB] FAIL inactive: score=%0d required 8", score);
    end
    game_active = 1'b1;
  endtask

  task automatic test_saturate();
    do_clear();
    burst(998, 2);
    checks++;
    if (score !== 12'd998) begin
      errors++;
      $display("[TB] FAIL preload998: score=%0d required 998", score);
    end
    burst(3, 2);
    exp_q.push_back(to_bcd(model));
    checks++;
    if (score !== 12'd999) begin
      errors++;
      $display("[TB] FAIL saturate: score=%0d required 999", score);
    end
    wait_drain("saturate");
    checks++;
    if (score_bcd !== 12'h999 || score !== 12'd999) begin
      errors++;
      $display("[TB] FAIL sat_bcd: bcd=%03h score=%0d required 999 999", score_bcd, score);
    end
  endtask

  task automatic test_high_score();
    logic seen;
    do_clear();
    burst(35, 2);
    exp_q.push_back(to_bcd(model));
    wait_drain("hs35");
    game_over = 1'b1;
    tick();
    checks++;
    if (new_high !== 1'b1 || high_score !== 12'd35) begin
      errors++;
      $display("[TB] FAIL high_update: new_high=%b high=%0d required 1 35", new_high, high_score);
    end
    tick();
    checks++;
    if (new_high !== 1'b0) begin
      errors++;
      $display("[TB] FAIL high_pulse_width: new_high=%b required 0", new_high);
    end
    game_over = 1'b0;
    tick();

    do_clear();
    burst(20, 2);
    exp_q.push_back(to_bcd(model));
    wait_drain("hs20");
    game_over = 1'b1;
    seen = 1'b0;
    repeat (3) begin
      tick();
      if (new_high) seen = 1'b1;
    end
    game_over = 1'b0;
    checks++;
    if (seen !== 1'b0 || high_score !== 12'd35) begin
      errors++;
      $display("[TB] FAIL high_lower: pulse=%b high=%0d required 0 35", seen, high_score);
    end

    do_clear();
    burst(35, 2);
    exp_q.push_back(to_bcd(model));
    wait_drain("hs35b");
    game_over = 1'b1;
    seen = 1'b0;
    repeat (3) begin
      tick();
      if (new_high) seen = 1'b1;
    end
    game_over = 1'b0;
    checks++;
    if (seen !== 1'b0 || high_score !== 12'd35) begin
      errors++;
      $display("[TB] FAIL high_equal: pulse=%b high=%0d required 0 35", seen, high_score);
    end
  endtask

  task automatic test_back_to_back();
    logic stale;
    do_clear();
    burst(41, 2);
    exp_q.push_back(to_bcd(model));
    wait_drain("b2b41");
    stale = 1'b0;
    point_in = 1'b1;
    tick();
    point_in = 1'b0;
    model++;
    repeat (2) begin
      tick();
      if (bcd_valid && score_bcd == 12'h042) stale = 1'b1;
    end
    point_in = 1'b1;
    tick();
    point_in = 1'b0;
    model++;
    exp_q.push_back(to_bcd(model));
    repeat (40) begin
      tick();
      if (bcd_valid && score_bcd == 12'h042) stale = 1'b1;
    end
    wait_drain("b2b43");
    checks++;
    if (stale !== 1'b0) begin
      errors++;
      $display("[TB] FAIL stale042: got valid 042 required never");
    end
    checks++;
    if (score_bcd !== 12'h043 || bcd_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL b2b_final: bcd=%03h valid=%b required 043 1", score_bcd, bcd_valid);
    end
  endtask

  task automatic test_clear_point();
    clear = 1'b1;
    point_in = 1'b1;
    tick();
    clear = 1'b0;
    point_in = 1'b0;
    model = 0;
    exp_q.push_back(to_bcd(model));
    checks++;
    if (score !== 12'd0) begin
      errors++;
      $display("[TB] FAIL clear_priority: score=%0d required 0", score);
    end
    wait_drain("clear");
  endtask

  task automatic test_reset_mid();
    pulse(1);
    repeat (6) tick();
    resetn = 1'b0;
    #1;
    checks++;
    if (score !== 12'd0 || high_score !== 12'd0 || new_high !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midreset_bin: score=%0d high=%0d new_high=%b required 0 0 0",
               score, high_score, new_high);
    end
    checks++;
    if (score_bcd !== 12'h000 || bcd_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midreset_bcd: bcd=%03h valid=%b required 000 1", score_bcd, bcd_valid);
    end
    tick();
    resetn = 1'b1;
    model = 0;
    repeat (20) tick();
    checks++;
    if (bcd_valid !== 1'b1 || score_bcd !== 12'h000 || exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL post_reset: valid=%b bcd=%03h required 1 000", bcd_valid, score_bcd);
    end
  endtask

  initial begin
    test_reset();
    test_count();
    test_hold_and_inactive();
    test_saturate();
    test_high_score();
    test_back_to_back();
    test_clear_point();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
